// File: rtl/leakyrelu_arbiter_if.sv
// leakyrelu_arbiter_if: requester, shared-unit and status bundle
// slave = arbiter side, master = environment side
interface leakyrelu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          flush;
  logic                          act_valid;
  logic [DATA_WIDTH-1:0]         act_data;
  logic                          act_o_valid;
  logic [DATA_WIDTH-1:0]         act_o_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;
  logic                          err_orphan;

  modport slave (
    input  req_valid, req_data, flush,
    input  act_o_valid, act_o_data,
    output req_ready, act_valid, act_data,
    output rsp_valid, rsp_data, busy, err_orphan
  );

  modport master (
    output req_valid, req_data, flush,
    output act_o_valid, act_o_data,
    input  req_ready, act_valid, act_data,
    input  rsp_valid, rsp_data, busy, err_orphan
  );
endinterface

// File: rtl/leakyrelu_arbiter.sv
// leakyrelu_arbiter: shares one fixed-latency LeakyReLU unit among NUM_REQ producers
// Define LRELU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins)
module leakyrelu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int LATENCY    = 8
) (
  input logic clk,
  input logic rst,
  leakyrelu_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam int QW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic                v;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic                  gnt_any;
  logic                  act_valid_q, act_valid_d;
  logic [DATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [ID_WIDTH-1:0]   act_id_q, act_id_d;
  tag_t [LATENCY-1:0]    tag_q, tag_d;
  tag_t                  tail;
  logic                  pipe_empty;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;
  logic [QW-1:0]         quiet_q, quiet_d;
  logic                  quiet;

  assign tail  = tag_q[LATENCY-1];
  assign quiet = (quiet_q != '0);

  // Grant search: first valid requester at or after ptr, wrapping
  always_comb begin : grant_search
    int idx;
    idx     = 0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = (int'(ptr) + o) % NUM_REQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_WIDTH'(idx);
      end
    end
    if (state_q == S_DRAIN || bus.flush) begin
      gnt_any = 1'b0;
    end
    grant = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
  end

`ifdef LRELU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  // Pointer moves past the requester that just transferred
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ?
              '0 : gnt_id + ID_WIDTH'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // Issue register plus tag shift pipe aligned to the unit latency
  always_comb begin
    act_valid_d = gnt_any;
    act_data_d  = act_data_q;
    act_id_d    = act_id_q;
    if (gnt_any) begin
      act_data_d = bus.req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      act_id_d   = gnt_id;
    end
    tag_d    = tag_q;
    tag_d[0] = {act_valid_q, act_id_q};
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Route results by tail tag; flag orphans and lost tags
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    quiet_d     = quiet ? quiet_q - QW'(1) : quiet_q;
    if (bus.act_o_valid && tail.v) begin
      rsp_valid_d = NUM_REQ'(1) << tail.id;
      rsp_data_d  = bus.act_o_data;
    end
    if (bus.act_o_valid && !tail.v && !quiet) err_d = 1'b1;
    if (!bus.act_o_valid && tail.v)           err_d = 1'b1;
  end

  // Layer quiesce FSM
  always_comb begin
    pipe_empty = !act_valid_q;
    for (int i = 0; i < LATENCY; i++) begin
      if (tag_q[i].v) pipe_empty = 1'b0;
    end
    state_d = state_q;
    unique case (1'b1)
      state_q == S_IDLE:
        if (|bus.req_valid) state_d = S_ACTIVE;
      state_q == S_ACTIVE:
        if (bus.flush) state_d = S_DRAIN;
        else if (pipe_empty && !(|bus.req_valid)) state_d = S_IDLE;
      state_q == S_DRAIN:
        if (pipe_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      act_valid_q <= 1'b0;
      act_data_q  <= '0;
      act_id_q    <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      quiet_q     <= QW'(LATENCY);
    end else begin
      state_q     <= state_d;
      act_valid_q <= act_valid_d;
      act_data_q  <= act_data_d;
      act_id_q    <= act_id_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      quiet_q     <= quiet_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.act_valid  = act_valid_q;
  assign bus.act_data   = act_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err_orphan = err_q;
endmodule

// File: tb/tb_leakyrelu_arbiter.sv
// tb_leakyrelu_arbiter: randomized bench with a queue-based reference model
// Shared unit is modelled as an untagged LATENCY-deep delay line
module tb_leakyrelu_arbiter;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int L  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   edges = 0;
  int   mptr  = 0;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  leakyrelu_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  leakyrelu_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(2), .LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Stand-in unit: x*0.1 for -2.0, a fixed bit scramble otherwise
  function automatic logic [31:0] unit_fn(input logic [31:0] x);
    if (x == 32'hC000_0000) return 32'hBE4C_CCCD;
    return {x[15:0], x[31:16]} ^ 32'h3C3C_A5A5;
  endfunction

  logic [L-1:0] mv = '0;
  logic [31:0]  md [L];
  logic         inj_v = 1'b0;
  logic [31:0]  inj_d = '0;

  // Unit model ignores rst so pre-reset ops keep emerging
  always @(posedge clk) begin
    mv <= {mv[L-2:0], bus.act_valid};
    md[0] <= unit_fn(bus.act_data);
    for (int i = 1; i < L; i++) md[i] <= md[i-1];
  end

  assign bus.act_o_valid = mv[L-1] | inj_v;
  assign bus.act_o_data  = inj_v ? inj_d : md[L-1];

  // Response scoreboard: each accepted op must return exactly on its due edge
  always @(negedge clk) begin
    logic [N-1:0] ev;
    logic [31:0]  ed;
    ev = '0;
    ed = '0;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == edges) begin
        ev = N'(1) << sb[0].id;
        ed = sb[0].d;
        void'(sb.pop_front());
      end
      total++;
      if (bus.rsp_valid !== ev) begin
        bad++;
        $display("FAIL rsp_valid edge=%0d got=%b exp=%b", edges, bus.rsp_valid, ev);
      end else if (ev != '0) begin
        total++;
        if (bus.rsp_data !== ed) begin
          bad++;
          $display("FAIL rsp_data edge=%0d got=%h exp=%h", edges, bus.rsp_data, ed);
        end
      end
    end
  end

  // One cycle of stimulus; predicts the grant from the arbitration rule
  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                      input logic fl, input logic blk, output int g);
    int start;
    logic [N-1:0] eg;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.flush     = fl;
    #1;
    g  = -1;
    eg = '0;
`ifdef LRELU_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = mptr;
`endif
    if (!fl && !blk) begin
      for (int o = 0; o < N; o++) begin
        if (g < 0 && v[(start + o) % N]) g = (start + o) % N;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    total++;
    if (bus.req_ready !== eg) begin
      bad++;
      $display("FAIL req_ready edge=%0d got=%b exp=%b", edges, bus.req_ready, eg);
    end
    if (g >= 0) begin
      sb.push_back('{due: edges + L + 2, id: g, d: unit_fn(d[g*DW +: DW])});
      mptr = (g + 1) % N;
    end
  endtask

  task automatic drain();
    int gd;
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      step('0, '0, 1'b0, 1'b0, gd);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d exp=0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.flush     = 1'b0;
    inj_v = 1'b0;
    sb.delete();
    mptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.flush     = 1'b0;
    sb.delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.act_valid, bus.act_data, bus.rsp_valid,
         bus.rsp_data, bus.busy, bus.err_orphan} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b av=%b ad=%h rv=%b rd=%h busy=%b err=%b exp=all0",
               bus.req_ready, bus.act_valid, bus.act_data, bus.rsp_valid,
               bus.rsp_data, bus.busy, bus.err_orphan);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [N*DW-1:0] d;
    int g;
    do_reset();
    d = '0;
    d[2*DW +: DW] = 32'hC000_0000;
    step(4'b0100, d, 1'b0, 1'b0, g);
    total++;
    if (g != 2) begin
      bad++;
      $display("FAIL single_grant got=%0d exp=2", g);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.act_valid !== 1'b1 || bus.act_data !== 32'hC000_0000) begin
      bad++;
      $display("FAIL single_issue got v=%b d=%h exp v=1 d=c0000000",
               bus.act_valid, bus.act_data);
    end
    step('0, '0, 1'b0, 1'b0, g);
    @(posedge clk);
    #1;
    total++;
    if (bus.act_valid !== 1'b0 || bus.act_data !== 32'hC000_0000) begin
      bad++;
      $display("FAIL single_idle got v=%b d=%h exp v=0 d=c0000000",
               bus.act_valid, bus.act_data);
    end
    drain();
  endtask

  task automatic test_all_valid();
    logic [N*DW-1:0] d;
    int g;
    int eg;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(4'b1111, d, 1'b0, 1'b0, g);
`ifdef LRELU_ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = i % N;
`endif
      total++;
      if (g != eg) begin
        bad++;
        $display("FAIL order cycle=%0d got=%0d exp=%0d", i, g, eg);
      end
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    step(4'b1110, d, 1'b0, 1'b0, g);
    drain();
  endtask

  task automatic test_flush();
    logic [N*DW-1:0] d;
    int g;
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(4'b1111, d, 1'b0, 1'b0, g);
    end
    step(4'b1111, d, 1'b1, 1'b1, g);
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      step(4'b1111, d, 1'b0, 1'b1, g);
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL drain_busy got=%b exp=1", bus.busy);
      end
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL flush_timeout left=%0d exp=0", sb.size());
    end
    @(negedge clk);
    bus.req_valid = '0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_fall got=%b exp=0", bus.busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_orphan();
    do_reset();
    repeat (L + 1) @(negedge clk);
    inj_d = $urandom;
    inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    total++;
    if (bus.err_orphan !== 1'b1) begin
      bad++;
      $display("FAIL orphan_set got=%b exp=1", bus.err_orphan);
    end
    repeat (5) @(negedge clk);
    total++;
    if (bus.err_orphan !== 1'b1) begin
      bad++;
      $display("FAIL orphan_sticky got=%b exp=1", bus.err_orphan);
    end
  endtask

  task automatic test_reset_inflight();
    logic [N*DW-1:0] d;
    int g;
    int stale;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(4'b0001, d, 1'b0, 1'b0, g);
    end
    step('0, '0, 1'b0, 1'b0, g);
    step('0, '0, 1'b0, 1'b0, g);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    mptr = 0;
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < L + 4; i++) begin
      @(negedge clk);
      if (bus.act_o_valid) stale++;
      total++;
      if (bus.err_orphan !== 1'b0) begin
        bad++;
        $display("FAIL stale_err cycle=%0d got=%b exp=0", i, bus.err_orphan);
      end
    end
    total++;
    if (stale == 0) begin
      bad++;
      $display("FAIL stale_seen got=0 exp>0");
    end
  endtask

  task automatic test_random();
    logic [N*DW-1:0] d;
    logic [N-1:0] v;
    int g;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v = N'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      step(v, d, 1'b0, 1'b0, g);
    end
    drain();
    total++;
    if (bus.err_orphan !== 1'b0) begin
      bad++;
      $display("FAIL random_err got=%b exp=0", bus.err_orphan);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL random_idle got=%b exp=0", bus.busy);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.flush     = 1'b0;
    test_reset();
    test_single();
    test_all_valid();
    test_flush();
    test_random();
    test_orphan();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
